dmem_bridge: RTL and testbench

- Sits directly downstream of the datapath memory stage. Consumes the M-stage access (address, write data, byte strobes, size) and converts it into a split-transaction SRAM-like data-bus access (req/addr_ok/data_ok).
- Returns load data to the M/W pipeline register path.
- Raises `stall_mem` to freeze the pipeline until the access completes.
- Guarantees each M-stage instruction issues exactly one bus transaction, even if the pipeline stays stalled for other reasons, such as the divider.

---
 rtl/dmem_pkg.sv | 39 +++
 rtl/dmem_bridge.sv | 126 ++++++++++++
 tb/tb_dmem_bridge.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory bridge: FSM states, access
// sizes, request control payload and the alignment check.
package dmem_pkg;

  localparam int unsigned STRB_W = 4;
  localparam int unsigned SIZE_W = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam logic [SIZE_W-1:0] SZ_BYTE = 2'd0;
  localparam logic [SIZE_W-1:0] SZ_HALF = 2'd1;
  localparam logic [SIZE_W-1:0] SZ_WORD = 2'd2;

  // Control fields of one captured bus request.
  typedef struct packed {
    logic              wr;
    logic [SIZE_W-1:0] size;
    logic [STRB_W-1:0] wstrb;
  } req_ctl_t;

  // Half needs addr[0] == 0, word needs addr[1:0] == 0; bytes are always aligned.
  function automatic logic misaligned(input logic [SIZE_W-1:0] size,
                                      input logic [1:0]        addr_lo);
    logic bad;
    bad = 1'b0;
    case (size)
      SZ_HALF: bad = addr_lo[0];
      SZ_WORD: bad = (addr_lo != 2'd0);
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/dmem_bridge.sv
// M-stage to split-transaction data-bus bridge; one bus transaction per M
// instruction. Optional misalignment exceptions under DMEM_ALIGN_CHECK_EN.
module dmem_bridge
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              memenM,
  input  logic              memwriteM,
  input  logic [1:0]        sizeM,
  input  logic [3:0]        sig_write,
  input  logic [ADDR_W-1:0] aluoutM,
  input  logic [DATA_W-1:0] writedataM,
  input  logic              pipe_adv,
  output logic              stall_mem,
  output logic [DATA_W-1:0] readdataM,
`ifdef DMEM_ALIGN_CHECK_EN
  output logic              adelM,
  output logic              adesM,
`endif
  output logic              data_sram_req,
  output logic              data_sram_wr,
  output logic [1:0]        data_sram_size,
  output logic [ADDR_W-1:0] data_sram_addr,
  output logic [3:0]        data_sram_wstrb,
  output logic [DATA_W-1:0] data_sram_wdata,
  input  logic              data_sram_addr_ok,
  input  logic              data_sram_data_ok,
  input  logic [DATA_W-1:0] data_sram_rdata
);

  state_e            state_q, state_nxt;
  req_ctl_t          ctl_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              capture_c;
  logic              latch_c;
  logic              misalign_c;

`ifdef DMEM_ALIGN_CHECK_EN
  assign misalign_c = misaligned(sizeM, aluoutM[1:0]);
  // Exception flags hold for as long as the faulting instruction sits in M.
  assign adelM = rst && (state_q == IDLE) && memenM && misalign_c && !memwriteM;
  assign adesM = rst && (state_q == IDLE) && memenM && misalign_c &&  memwriteM;
`else
  assign misalign_c = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_nxt;
  end

  // Next state, stall and register-enable decode.
  always_comb begin
    state_nxt = state_q;
    stall_mem = 1'b0;
    capture_c = 1'b0;
    latch_c   = 1'b0;
    case (state_q)
      IDLE: begin
        // Reset gating keeps stall low while rst is held, even with memenM high.
        if (rst && memenM && !misalign_c) begin
          capture_c = 1'b1;
          stall_mem = 1'b1;
          state_nxt = REQ;
        end
      end
      REQ: begin
        stall_mem = 1'b1;
        if (data_sram_addr_ok) begin
          if (data_sram_data_ok) begin
            latch_c   = !ctl_q.wr;
            state_nxt = DONE;
          end else begin
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        stall_mem = 1'b1;
        if (data_sram_data_ok) begin
          latch_c   = !ctl_q.wr;
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (pipe_adv) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Request payload and load-data registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctl_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      if (capture_c) begin
        ctl_q.wr    <= memwriteM;
        ctl_q.size  <= sizeM;
        ctl_q.wstrb <= memwriteM ? sig_write : 4'b0000;
        addr_q      <= aluoutM;
        wdata_q     <= writedataM;
      end
      if (latch_c) rdata_q <= data_sram_rdata;
    end
  end

  assign data_sram_req   = (state_q == REQ);
  assign data_sram_wr    = ctl_q.wr;
  assign data_sram_size  = ctl_q.size;
  assign data_sram_wstrb = ctl_q.wstrb;
  assign data_sram_addr  = addr_q;
  assign data_sram_wdata = wdata_q;
  assign readdataM       = rdata_q;

endmodule

// File: tb/tb_dmem_bridge.sv
// Directed self-checking bench for dmem_bridge; define DMEM_ALIGN_CHECK_EN to
// exercise the misalignment exception outputs.
module tb_dmem_bridge;
  import dmem_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        memenM, memwriteM, pipe_adv;
  logic [1:0]  sizeM;
  logic [3:0]  sig_write;
  logic [31:0] aluoutM, writedataM;
  logic        stall_mem;
  logic [31:0] readdataM;
  logic        data_sram_req, data_sram_wr;
  logic [1:0]  data_sram_size;
  logic [31:0] data_sram_addr, data_sram_wdata, data_sram_rdata;
  logic [3:0]  data_sram_wstrb;
  logic        data_sram_addr_ok, data_sram_data_ok;
`ifdef DMEM_ALIGN_CHECK_EN
  logic        adelM, adesM;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dmem_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .memenM(memenM), .memwriteM(memwriteM), .sizeM(sizeM), .sig_write(sig_write),
    .aluoutM(aluoutM), .writedataM(writedataM), .pipe_adv(pipe_adv),
    .stall_mem(stall_mem), .readdataM(readdataM),
`ifdef DMEM_ALIGN_CHECK_EN
    .adelM(adelM), .adesM(adesM),
`endif
    .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
    .data_sram_size(data_sram_size), .data_sram_addr(data_sram_addr),
    .data_sram_wstrb(data_sram_wstrb), .data_sram_wdata(data_sram_wdata),
    .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok),
    .data_sram_rdata(data_sram_rdata)
  );

  // Drive one M access and play the bus: accept on req cycle aok_wait (0-based),
  // respond dok_wait cycles after acceptance (0 = same cycle). Returns in DONE.
  task automatic do_access(input logic wr, input logic [1:0] sz, input logic [3:0] strb,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input int aok_wait, input int dok_wait, input logic [31:0] rdata,
                           output int req_c, output int stall_c, output int aok_c,
                           output logic [31:0] o_addr, output logic [31:0] o_wdata,
                           output logic o_wr, output logic [1:0] o_size,
                           output logic [3:0] o_wstrb);
    bit accepted = 0, responded = 0, done = 0;
    int wait_c = 0;
    req_c = 0; stall_c = 0; aok_c = 0;
    o_addr = '0; o_wdata = '0; o_wr = 1'b0; o_size = '0; o_wstrb = '0;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      @(negedge clk);
      if (cyc == 0) begin
        memenM = 1'b1; memwriteM = wr; sizeM = sz; sig_write = strb;
        aluoutM = addr; writedataM = wdata; pipe_adv = 1'b0;
      end
      data_sram_addr_ok = 1'b0;
      data_sram_data_ok = 1'b0;
      #1;
      if (data_sram_req) begin
        if (!accepted && req_c == aok_wait) begin
          data_sram_addr_ok = 1'b1; aok_c++; accepted = 1;
          o_addr = data_sram_addr; o_wdata = data_sram_wdata; o_wr = data_sram_wr;
          o_size = data_sram_size; o_wstrb = data_sram_wstrb;
          if (dok_wait == 0) begin
            data_sram_data_ok = 1'b1; data_sram_rdata = rdata; responded = 1;
          end
        end
        req_c++;
      end else if (accepted && !responded) begin
        wait_c++;
        if (wait_c == dok_wait) begin
          data_sram_data_ok = 1'b1; data_sram_rdata = rdata; responded = 1;
        end
      end
      #1;
      if (stall_mem) stall_c++;
      else if (responded) done = 1;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL access_timeout: addr=%08h never reached DONE, required completion within 40 cycles", addr);
    end
  endtask

  task automatic leave_done();
    @(negedge clk);
    memenM = 1'b0; pipe_adv = 1'b1;
    @(negedge clk);
    pipe_adv = 1'b0;
    #1;
    checks++;
    if (data_sram_req !== 1'b0 || stall_mem !== 1'b0) begin
      errors++;
      $display("FAIL leave_done: req=%b stall=%b, required req=0 stall=0", data_sram_req, stall_mem);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #3;
    checks++;
    if ({data_sram_req, data_sram_wr, stall_mem} !== 3'b000) begin
      errors++;
      $display("FAIL reset_ctrl: req/wr/stall=%b, required 000", {data_sram_req, data_sram_wr, stall_mem});
    end
    checks++;
    if ({data_sram_addr, data_sram_wdata, data_sram_wstrb, data_sram_size} !== '0 || readdataM !== 32'h0) begin
      errors++;
      $display("FAIL reset_data: addr=%08h wdata=%08h wstrb=%b size=%0d rdata=%08h, required all 0",
               data_sram_addr, data_sram_wdata, data_sram_wstrb, data_sram_size, readdataM);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_word_load();
    int rq, st, ak; logic [31:0] a, w; logic wr; logic [1:0] sz; logic [3:0] sb;
    do_access(1'b0, SZ_WORD, 4'hF, 32'h0000_1000, 32'hCAFE_F00D, 1, 1, 32'hDEAD_BEEF,
              rq, st, ak, a, w, wr, sz, sb);
    checks++;
    if (rq !== 2 || st !== 4 || ak !== 1) begin
      errors++;
      $display("FAIL word_load_timing: req=%0d stall=%0d aok=%0d, required 2/4/1", rq, st, ak);
    end
    checks++;
    if (a !== 32'h0000_1000 || wr !== 1'b0 || sz !== 2'd2 || sb !== 4'b0000) begin
      errors++;
      $display("FAIL word_load_bus: addr=%08h wr=%b size=%0d wstrb=%b, required 00001000/0/2/0000", a, wr, sz, sb);
    end
    checks++;
    if (readdataM !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL word_load_data: readdataM=%08h, required deadbeef", readdataM);
    end
    leave_done();
  endtask

  task automatic test_byte_store();
    int rq, st, ak; logic [31:0] a, w; logic wr; logic [1:0] sz; logic [3:0] sb;
    do_access(1'b1, SZ_BYTE, 4'b1000, 32'h0000_1003, 32'h7700_0000, 0, 1, 32'h1234_5678,
              rq, st, ak, a, w, wr, sz, sb);
    checks++;
    if (wr !== 1'b1 || sz !== 2'd0 || sb !== 4'b1000 || w !== 32'h7700_0000 || a !== 32'h0000_1003) begin
      errors++;
      $display("FAIL byte_store_bus: wr=%b size=%0d wstrb=%b wdata=%08h addr=%08h, required 1/0/1000/77000000/00001003",
               wr, sz, sb, w, a);
    end
    checks++;
    if (rq !== 1 || st !== 3) begin
      errors++;
      $display("FAIL byte_store_timing: req=%0d stall=%0d, required 1/3", rq, st);
    end
    checks++;
    if (readdataM !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL byte_store_rdata: readdataM=%08h, required deadbeef (unchanged)", readdataM);
    end
    leave_done();
  endtask

  task automatic test_back_to_back();
    int rq, st, ak; logic [31:0] a, w; logic wr; logic [1:0] sz; logic [3:0] sb;
    do_access(1'b0, SZ_WORD, 4'h0, 32'h0000_1004, 32'h0, 0, 0, 32'h0BAD_F00D,
              rq, st, ak, a, w, wr, sz, sb);
    checks++;
    if (rq !== 1 || st !== 2 || readdataM !== 32'h0BAD_F00D) begin
      errors++;
      $display("FAIL same_cycle: req=%0d stall=%0d rdata=%08h, required 1/2/0badf00d", rq, st, readdataM);
    end
    // Hold DONE with the same instruction still in M.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      memenM = 1'b1; pipe_adv = 1'b0;
      #1;
      checks++;
      if (data_sram_req !== 1'b0 || stall_mem !== 1'b0 || readdataM !== 32'h0BAD_F00D) begin
        errors++;
        $display("FAIL done_hold[%0d]: req=%b stall=%b rdata=%08h, required 0/0/0badf00d",
                 i, data_sram_req, stall_mem, readdataM);
      end
    end
    @(negedge clk);
    pipe_adv = 1'b1; aluoutM = 32'h0000_1008;
    do_access(1'b0, SZ_WORD, 4'h0, 32'h0000_1008, 32'h0, 0, 1, 32'h1122_3344,
              rq, st, ak, a, w, wr, sz, sb);
    checks++;
    if (rq !== 1 || ak !== 1 || st !== 3 || a !== 32'h0000_1008 || readdataM !== 32'h1122_3344) begin
      errors++;
      $display("FAIL fresh_req: req=%0d aok=%0d stall=%0d addr=%08h rdata=%08h, required 1/1/3/00001008/11223344",
               rq, ak, st, a, readdataM);
    end
    leave_done();
  endtask

`ifdef DMEM_ALIGN_CHECK_EN
  task automatic test_align();
    @(negedge clk);
    memenM = 1'b1; memwriteM = 1'b0; sizeM = SZ_WORD; aluoutM = 32'h0000_1002; pipe_adv = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (adelM !== 1'b1 || adesM !== 1'b0 || data_sram_req !== 1'b0 || stall_mem !== 1'b0) begin
        errors++;
        $display("FAIL adel[%0d]: adel=%b ades=%b req=%b stall=%b, required 1/0/0/0",
                 i, adelM, adesM, data_sram_req, stall_mem);
      end
      @(negedge clk);
    end
    memwriteM = 1'b1; sizeM = SZ_HALF; aluoutM = 32'h0000_1001; sig_write = 4'b0011;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (adesM !== 1'b1 || adelM !== 1'b0 || data_sram_req !== 1'b0 || stall_mem !== 1'b0) begin
        errors++;
        $display("FAIL ades[%0d]: ades=%b adel=%b req=%b stall=%b, required 1/0/0/0",
                 i, adesM, adelM, data_sram_req, stall_mem);
      end
      @(negedge clk);
    end
    memenM = 1'b0;
    #1;
    checks++;
    if (adelM !== 1'b0 || adesM !== 1'b0) begin
      errors++;
      $display("FAIL align_clear: adel=%b ades=%b, required 0/0", adelM, adesM);
    end
  endtask
`else
  task automatic test_misaligned_forward();
    int rq, st, ak; logic [31:0] a, w; logic wr; logic [1:0] sz; logic [3:0] sb;
    do_access(1'b0, SZ_WORD, 4'h0, 32'h0000_1002, 32'h0, 0, 1, 32'h55AA_55AA,
              rq, st, ak, a, w, wr, sz, sb);
    checks++;
    if (rq !== 1 || a !== 32'h0000_1002 || readdataM !== 32'h55AA_55AA) begin
      errors++;
      $display("FAIL misaligned_forward: req=%0d addr=%08h rdata=%08h, required 1/00001002/55aa55aa",
               rq, a, readdataM);
    end
    leave_done();
  endtask
`endif

  task automatic test_reset_in_wait();
    @(negedge clk);
    memenM = 1'b1; memwriteM = 1'b0; sizeM = SZ_WORD; aluoutM = 32'h0000_2000; pipe_adv = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (data_sram_req !== 1'b1) begin
      errors++;
      $display("FAIL rst_wait_req: req=%b, required 1", data_sram_req);
    end
    data_sram_addr_ok = 1'b1;
    @(negedge clk);
    data_sram_addr_ok = 1'b0;
    #1;
    checks++;
    if (data_sram_req !== 1'b0 || stall_mem !== 1'b1) begin
      errors++;
      $display("FAIL rst_wait_state: req=%b stall=%b, required 0/1", data_sram_req, stall_mem);
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({data_sram_req, data_sram_wr, stall_mem} !== 3'b000 || data_sram_addr !== 32'h0 || readdataM !== 32'h0) begin
      errors++;
      $display("FAIL rst_wait_clear: req/wr/stall=%b addr=%08h rdata=%08h, required 000/0/0",
               {data_sram_req, data_sram_wr, stall_mem}, data_sram_addr, readdataM);
    end
    @(negedge clk);
    rst = 1'b1; memenM = 1'b0;
    data_sram_data_ok = 1'b1; data_sram_rdata = 32'hBAD0_BAD0;
    @(negedge clk);
    data_sram_data_ok = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if (readdataM !== 32'h0 || stall_mem !== 1'b0 || data_sram_req !== 1'b0) begin
        errors++;
        $display("FAIL stray_data_ok[%0d]: rdata=%08h stall=%b req=%b, required 0/0/0",
                 i, readdataM, stall_mem, data_sram_req);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    rst = 1'b0; memenM = 1'b0; memwriteM = 1'b0; sizeM = 2'd0; sig_write = 4'h0;
    aluoutM = '0; writedataM = '0; pipe_adv = 1'b0;
    data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b0; data_sram_rdata = '0;
    test_reset();
    test_word_load();
    test_byte_store();
    test_back_to_back();
`ifdef DMEM_ALIGN_CHECK_EN
    test_align();
`else
    test_misaligned_forward();
`endif
    test_reset_in_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
